// File: rtl/conv_frame_sequencer_if.sv
// Stream bundle between the pixel FWFT, the frame sequencer and the conv MACC enable.
// A pixel transfers on any cycle where i_feature_valid and o_rd_en are both high; o_rd_en already
// includes i_ds_ready, so it never rises while the conv/pool path is stalled.
interface conv_frame_sequencer_if #(
    parameter int CW = 6
);
    logic          i_feature_valid;
    logic          i_ds_ready;
    logic          o_rd_en;
    logic          o_window_valid;
    logic [CW-1:0] o_out_row;
    logic [CW-1:0] o_out_col;

    modport master (
        input  i_feature_valid,
        input  i_ds_ready,
        output o_rd_en,
        output o_window_valid,
        output o_out_row,
        output o_out_col
    );

    modport slave (
        output i_feature_valid,
        output i_ds_ready,
        input  o_rd_en,
        input  o_window_valid,
        input  o_out_row,
        input  o_out_col
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the conv stage: raster tracking, KxK window enable with output
// coordinates, downstream stall, pipeline drain and a single-cycle frame completion pulse.
module conv_frame_sequencer #(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int K        = 5,
    parameter int PIPE_LAT = 4,
    parameter int CW       = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    conv_frame_sequencer_if.master bus,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic [2:0]             o_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CW-1:0] C_COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_ROW_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0] C_KM1       = CW'(K - 1);
    localparam logic [CW-1:0] C_FILL_LAST = CW'(K - 2);
    localparam logic [DW-1:0] C_DRAIN     = DW'(PIPE_LAT - 1);

    state_t        r_state;
    logic [CW-1:0] r_px_col;
    logic [CW-1:0] r_px_row;
    logic [CW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;
    logic [DW-1:0] r_drain_cnt;
    logic          r_window_valid;
    logic          r_busy;
    logic          r_frame_done;

    logic w_accepting;
    logic w_acc;
    logic w_col_last;
    logic w_row_last;
    logic w_in_window;

    assign w_accepting = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_acc       = bus.o_rd_en & bus.i_feature_valid;
    assign w_col_last  = (r_px_col == C_COL_LAST);
    assign w_row_last  = (r_px_row == C_ROW_LAST);
    // Position of the pixel being accepted, before the counters advance.
    assign w_in_window = (r_px_row >= C_KM1) && (r_px_col >= C_KM1);

    assign bus.o_rd_en        = w_accepting & bus.i_ds_ready;
    assign bus.o_window_valid = r_window_valid;
    assign bus.o_out_row      = r_out_row;
    assign bus.o_out_col      = r_out_col;
    assign o_busy             = r_busy;
    assign o_frame_done       = r_frame_done;
    assign o_state            = r_state;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= S_IDLE;
            r_px_col       <= '0;
            r_px_row       <= '0;
            r_out_row      <= '0;
            r_out_col      <= '0;
            r_drain_cnt    <= '0;
            r_window_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            // Abort outranks everything outside IDLE, including the final-pixel accept.
            if (i_abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_px_col    <= '0;
                r_px_row    <= '0;
                r_drain_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state  <= S_FILL;
                            r_busy   <= 1'b1;
                            r_px_col <= '0;
                            r_px_row <= '0;
                        end
                    end
                    S_FILL, S_RUN: begin
                        if (w_acc) begin
                            if (w_col_last) begin
                                r_px_col <= '0;
                                r_px_row <= r_px_row + 1'b1;
                            end else begin
                                r_px_col <= r_px_col + 1'b1;
                            end
                            if (w_in_window) begin
                                r_window_valid <= 1'b1;
                                r_out_row      <= r_px_row - C_KM1;
                                r_out_col      <= r_px_col - C_KM1;
                            end
                            if ((r_state == S_FILL) && w_col_last && (r_px_row == C_FILL_LAST)) begin
                                r_state <= S_RUN;
                            end
                            if ((r_state == S_RUN) && w_col_last && w_row_last) begin
                                r_state     <= S_DRAIN;
                                r_drain_cnt <= C_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain_cnt == '0) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer: a cycle model predicts handshake/status outputs
// and pushes expected window coordinates into a queue that is popped on every window pulse.
module tb_conv_frame_sequencer;
    localparam int IMG_W    = 32;
    localparam int IMG_H    = 32;
    localparam int K        = 5;
    localparam int PIPE_LAT = 4;
    localparam int CW       = 6;
    localparam int N_PIX    = IMG_W * IMG_H;
    localparam int N_WIN    = (IMG_H - K + 1) * (IMG_W - K + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       frame_done;
    logic [2:0] state;

    always #5 clk = ~clk;

    conv_frame_sequencer_if #(.CW(CW)) bus ();

    conv_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIPE_LAT(PIPE_LAT), .CW(CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .bus          (bus),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_state      (state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [2*CW-1:0] exp_q[$];

    // Reference model state
    logic m_active;
    logic exp_wv;
    int   pix;
    int   fd_cd;
    int   cyc;
    int   win_cnt;
    int   done_cnt;
    int   last_win_cyc;
    int   fd_cyc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        exp_wv   = 1'b0;
        pix      = 0;
        fd_cd    = 0;
        exp_q.delete();
    endtask

    // Runs at the falling edge: compare outputs, then advance the model by this cycle's inputs.
    task automatic monitor();
        logic            exp_fd;
        logic            exp_rd_en;
        logic            acc;
        logic            idle;
        logic [2*CW-1:0] e;
        int              row;
        int              col;
        cyc++;
        exp_fd = 1'b0;
        if (fd_cd > 0) begin
            fd_cd--;
            exp_fd = (fd_cd == 0);
        end
        exp_rd_en = m_active & bus.i_ds_ready;
        check_eq("rd_en", 32'(bus.o_rd_en), 32'(exp_rd_en));
        check_eq("window_valid", 32'(bus.o_window_valid), 32'(exp_wv));
        check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
        check_eq("busy", 32'(busy), 32'(m_active | (fd_cd > 0) | exp_fd));
        if (bus.o_window_valid) begin
            win_cnt++;
            last_win_cyc = cyc;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check_eq("win_coord", 32'({bus.o_out_row, bus.o_out_col}), 32'(e));
        end
        if (frame_done) begin
            done_cnt++;
            fd_cyc = cyc;
        end

        exp_wv = 1'b0;
        idle   = !m_active && (fd_cd == 0) && !exp_fd;
        acc    = exp_rd_en & bus.i_feature_valid;
        if (idle) begin
            if (start) begin
                m_active = 1'b1;
                pix      = 0;
            end
        end else if (abort) begin
            m_active = 1'b0;
            fd_cd    = 0;
            pix      = 0;
        end else if (acc) begin
            row = pix / IMG_W;
            col = pix % IMG_W;
            if (row >= K - 1 && col >= K - 1) begin
                exp_wv = 1'b1;
                exp_q.push_back({CW'(row - (K - 1)), CW'(col - (K - 1))});
            end
            pix++;
            if (pix == N_PIX) begin
                m_active = 1'b0;
                fd_cd    = PIPE_LAT + 1;
            end
        end
    endtask

    task automatic drive(input logic fv, input logic dr, input logic st, input logic ab);
        bus.i_feature_valid = fv;
        bus.i_ds_ready      = dr;
        start               = st;
        abort               = ab;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input int gap_pct, input int stall_at,
                             input int start_at, input int abort_at,
                             input int exp_win, input int exp_done);
        int   stall_left = 10;
        bit   start_done = 1'b0;
        bit   aborted    = 1'b0;
        int   budget     = 0;
        logic fv;
        logic dr;
        logic st;
        logic ab;
        win_cnt      = 0;
        done_cnt     = 0;
        last_win_cyc = 0;
        fd_cyc       = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        while (done_cnt == 0 && !aborted && budget < 5000) begin
            fv = ($urandom_range(99) >= gap_pct);
            dr = 1'b1;
            st = 1'b0;
            ab = 1'b0;
            if (pix == stall_at && stall_left > 0 && m_active) begin
                dr = 1'b0;
                stall_left--;
            end
            if (pix == start_at && !start_done) begin
                st         = 1'b1;
                start_done = 1'b1;
            end
            if (pix == abort_at && m_active) begin
                fv      = 1'b1;
                ab      = 1'b1;
                aborted = 1'b1;
            end
            drive(fv, dr, st, ab);
            budget++;
        end
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq({name, "_windows"}, 32'(win_cnt), 32'(exp_win));
        check_eq({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
        check_eq({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        if (exp_done > 0) begin
            check_eq({name, "_done_latency"}, 32'(fd_cyc - last_win_cyc), 32'(PIPE_LAT));
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        start               = 1'b0;
        abort               = 1'b0;
        bus.i_feature_valid = 1'b0;
        bus.i_ds_ready      = 1'b0;
        cyc                 = 0;
        win_cnt             = 0;
        done_cnt            = 0;
        last_win_cyc        = 0;
        fd_cyc              = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd_en", 32'(bus.o_rd_en), 32'd0);
        check_eq("rst_window_valid", 32'(bus.o_window_valid), 32'd0);
        check_eq("rst_out_row", 32'(bus.o_out_row), 32'd0);
        check_eq("rst_out_col", 32'(bus.o_out_col), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);

        run_frame("full", 0, -1, -1, -1, N_WIN, 1);
        run_frame("gaps", 30, -1, -1, -1, N_WIN, 1);
        run_frame("stall", 0, 600, -1, -1, N_WIN, 1);
        run_frame("start_in_run", 0, -1, 700, -1, N_WIN, 1);
        // Pixels 0..499 accepted before the abort: rows 4..14 give 11*28, row 15 cols 4..19 give 16.
        run_frame("abort", 0, -1, -1, 500, 324, 0);
        run_frame("after_abort", 0, -1, -1, -1, N_WIN, 1);

        // Asynchronous reset in the middle of a frame, away from any clock edge
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (300) drive(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rd_en", 32'(bus.o_rd_en), 32'd0);
        check_eq("arst_window_valid", 32'(bus.o_window_valid), 32'd0);
        check_eq("arst_out_row", 32'(bus.o_out_row), 32'd0);
        check_eq("arst_out_col", 32'(bus.o_out_col), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_frame_done", 32'(frame_done), 32'd0);
        check_eq("arst_state", 32'(state), 32'd0);
        model_clear();
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("after_reset", 0, -1, -1, -1, N_WIN, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller for the conv stage. It sits between feature_fwft and conv, consuming one 8-bit pixel per accepted handshake.
- Tracks the input raster position and enables the conv MACCs only when a full KxK window exists. It also tags each conv output with its output coordinates.
- Stalls on downstream backpressure, drains the conv pipeline after the last pixel and pulses frame completion.

Parameters:
- IMG_W, 32, input frame width in pixels
- IMG_H, 32, input frame height in pixels
- K, 5, conv kernel size (stride 1, no padding)
- PIPE_LAT, 4, conv pipeline latency in cycles, from window-valid to result
- CW, 6, counter width; must satisfy 2^CW >= max(IMG_W, IMG_H)

Ports:
- i_clk  in  1  system clock (clk100m domain)
- i_rst  in  1  asynchronous, active-low reset
- i_start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE
- i_abort  in  1  synchronous frame abort
- i_feature_valid  in  1  FWFT has a pixel at its output
- i_ds_ready  in  1  conv/pool path can accept a new window
- o_rd_en  out  1  pop/accept pixel from FWFT
- o_window_valid  out  1  MACC enable: the accepted pixel completes a valid window
- o_out_row  out  CW  output row of the current window (0..IMG_H-K)
- o_out_col  out  CW  output column of the current window (0..IMG_W-K)
- o_busy  out  1  high in any state other than IDLE
- o_frame_done  out  1  single-cycle pulse after drain completes

Behaviour:
- Reset (i_rst=0, asynchronous): state goes to IDLE. All counters are cleared. Every output is 0.
- Accept condition: acc = o_rd_en & i_feature_valid.
- o_rd_en is combinational and equals (state==FILL or state==RUN) & i_ds_ready.
- Pixel counters px_col and px_row advance only on acc:
  - px_col increments.
  - At IMG_W-1, px_col wraps to 0 and px_row increments.
- States:
  - IDLE: when i_start=1, go to FILL and clear the counters.
  - FILL: active while px_row < K-1. When an acc occurs with px_col==IMG_W-1 and px_row==K-2, go to RUN.
  - RUN: on the acc at px_row==IMG_H-1 and px_col==IMG_W-1, go to DRAIN and load drain_cnt with PIPE_LAT-1.
  - DRAIN: o_rd_en=0. drain_cnt decrements each cycle. When drain_cnt reaches 0, go to DONE.
  - DONE: o_frame_done=1 for exactly one cycle, then go to IDLE.
- o_window_valid is registered. It is 1 in the cycle after an acc for which px_row>=K-1 and px_col>=K-1 (values before the increment). In the same cycle:
  - o_out_row = px_row-(K-1)
  - o_out_col = px_col-(K-1)
  - Otherwise o_window_valid=0, and o_out_row/o_out_col hold their last values.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1), which is 784 at the defaults.
- Gaps and stalls:
  - If i_feature_valid=0, or i_ds_ready=0, the counters hold and no window is produced.
  - No pixel is dropped or duplicated.
- i_start while o_busy=1 is ignored.
- i_abort=1 in any non-IDLE state:
  - Next state is IDLE and the counters clear.
  - o_window_valid is forced to 0 on the following cycle.
  - No o_frame_done is produced.
  - If i_abort and i_start are both high in IDLE, i_start wins.
- i_abort has priority over a simultaneous final-pixel acc.
- Back-to-back frames: i_start may be asserted in the cycle after o_frame_done, since the state is IDLE by then.
- Reset mid-frame: immediate return to IDLE. No partial frame_done. The FWFT contents are not flushed by this block.

Test Plan:
- Reset, then i_start; feed 1024 pixels with i_feature_valid=1 and i_ds_ready=1 throughout.
  - Exactly 784 o_window_valid pulses.
  - The first pulse is in the cycle after accepted pixel index 132, with (row,col)=(0,0).
  - The last pulse has (27,27).
  - o_frame_done fires 4 cycles after the final window pulse (DRAIN 4 cycles, then DONE).
- Random i_feature_valid gaps (about 30% low) over a full frame: still 784 windows, with row-major coordinates strictly sequential and no repeats or skips.
- Hold i_ds_ready=0 for 10 cycles mid-RUN:
  - o_rd_en=0 for those cycles.
  - No acc and no window.
  - Counters frozen.
  - Resumes with the next coordinate.
- Pulse i_start during RUN: no effect; the window count and frame_done timing are identical to the first scenario.
- Assert i_abort at accepted pixel 500:
  - IDLE on the next cycle, with o_busy=0.
  - No o_frame_done.
  - A new i_start then yields a full 784-window frame starting at (0,0).
- Drive i_rst=0 asynchronously mid-frame:
  - All outputs are 0 without waiting for a clock edge.
  - After release and i_start, behaviour matches the first scenario.
